// File: rtl/pcie_sw_pkg.sv
// Shared definitions for the switch ingress read side: FSM encoding,
// default bank geometry and the source-ID width helper.
package pcie_sw_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_NUM_FIFOS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_pop_arbiter_rr_select.sv
// Combinational round-robin search: first asserted request at or after
// start_i, wrapping modulo N (N is a power of two, so index overflow wraps).
module rr_select
    import pcie_sw_pkg::*;
#(
    parameter int N = DEF_NUM_FIFOS
) (
    input  logic [N-1:0]             req_i,
    input  logic [id_width(N)-1:0]   start_i,
    output logic [N-1:0]             gnt_oh_o,
    output logic [id_width(N)-1:0]   gnt_idx_o,
    output logic                     any_o
);

    localparam int IW = id_width(N);

    logic [IW-1:0] idx;

    always_comb begin
        idx       = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = start_i + IW'(i);
            if (!any_o && req_i[idx]) begin
                any_o     = 1'b1;
                gnt_idx_o = idx;
            end
        end
        gnt_oh_o = any_o ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Read-side controller for a FIFO bank: round-robin pops with burst limit,
// captures the returned word and presents it downstream with its source ID.
module fifo_pop_arbiter
    import pcie_sw_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int BURST     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_FIFOS-1:0]           fifo_empty,
    input  logic [NUM_FIFOS*DATA_SIZE-1:0] data_in,
    input  logic                           downstream_pause,
    output logic [NUM_FIFOS-1:0]           pop,
    output logic [DATA_SIZE-1:0]           data_out,
    output logic                           valid_out,
    output logic [id_width(NUM_FIFOS)-1:0] src_id,
    output logic                           pop_error
);

    localparam int IW = id_width(NUM_FIFOS);
    localparam int CW = $clog2(BURST + 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [NUM_FIFOS-1:0]   grant_oh_q, grant_oh_d;
    logic [CW-1:0]          burst_q, burst_d;
    logic                   popped_q, popped_d;
    logic [DATA_SIZE-1:0]   data_q, data_d;
    logic [IW-1:0]          src_q, src_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic [NUM_FIFOS-1:0]   rr_oh;
    logic [IW-1:0]          rr_idx;
    logic                   rr_any;
    logic                   go;
    logic                   keep;
    logic [DATA_SIZE-1:0]   word_sel;

    // Search starts one past the last grant so a finished or drained burst
    // hands over to the next FIFO in ring order.
    rr_select #(.N(NUM_FIFOS)) u_rr (
        .req_i     (~fifo_empty),
        .start_i   (grant_q + IW'(1)),
        .gnt_oh_o  (rr_oh),
        .gnt_idx_o (rr_idx),
        .any_o     (rr_any)
    );

    assign go   = !downstream_pause && rr_any;
    assign keep = (burst_q != '0) && (burst_q < CW'(BURST)) && !fifo_empty[grant_q];

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            if (grant_q == IW'(k)) word_sel = data_in[k*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        burst_d    = burst_q;
        popped_d   = popped_q;
        data_d     = data_q;
        src_d      = src_q;
        valid_d    = 1'b0;
        pop        = '0;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_POP;
            end
            ST_POP: begin
                pop      = grant_oh_q & ~fifo_empty;
                popped_d = |pop;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                data_d  = word_sel;
                src_d   = grant_q;
                valid_d = popped_q;
                state_d = go ? ST_POP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Grant is decided on entry to POP; burst_cnt of zero means no burst yet.
        if (state_d == ST_POP) begin
            if (keep) begin
                burst_d = burst_q + CW'(1);
            end else begin
                grant_d    = rr_idx;
                grant_oh_d = rr_oh;
                burst_d    = CW'(1);
            end
        end
    end

    assign err_d = err_q | (|(pop & fifo_empty));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= IW'(NUM_FIFOS - 1);
            grant_oh_q <= NUM_FIFOS'(1) << (NUM_FIFOS - 1);
            burst_q    <= '0;
            popped_q   <= 1'b0;
            data_q     <= '0;
            src_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            burst_q    <= burst_d;
            popped_q   <= popped_d;
            data_q     <= data_d;
            src_q      <= src_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out  = data_q;
    assign src_id    = src_q;
    assign valid_out = valid_q;
    assign pop_error = err_q;

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Read-side controller for a bank of `NUM_FIFOS` 4x8 FIFOs, the consumer end of the FIFO push/pop interface. It watches each FIFO's empty flag, issues one-hot pop strobes under round-robin arbitration with a configurable burst length, and captures the returned word. It presents each word downstream with a valid strobe and source ID, and honours a downstream pause. It sits between the per-port ingress FIFOs and the switch output stage.

## Interface
- `DATA_SIZE`, 8, word width in bits.
- `NUM_FIFOS`, 4, number of upstream FIFOs; must be a power of two, at least 2.
- `BURST`, 2, maximum consecutive words taken from one FIFO before the grant rotates; at least 1.
- `clk` input, 1 bit: single clock; all logic rises on its positive edge.
- `reset` input, 1 bit: synchronous, active-high.
- `fifo_empty` input, `NUM_FIFOS` bits: empty flag of each FIFO.
- `data_in` input, `NUM_FIFOS*DATA_SIZE` bits: FIFO pop data, concatenated; FIFO k occupies slice `[k*DATA_SIZE +: DATA_SIZE]`.
- `downstream_pause` input, 1 bit: when high, no new pop is issued.
- `pop` output, `NUM_FIFOS` bits: one-hot read strobe, or all zero.
- `data_out` output, `DATA_SIZE` bits: captured word.
- `valid_out` output, 1 bit: `data_out` and `src_id` are valid this cycle.
- `src_id` output, `log2(NUM_FIFOS)` bits: FIFO the word came from.
- `pop_error` output, 1 bit: sticky; set if a pop was issued to a FIFO whose empty flag was high at that edge.

## Operation
- FSM states:
  - IDLE: no pop in flight.
  - POP: `pop[grant]` is high this cycle.
  - CAPTURE: the FIFO data is returning.
- IDLE goes to POP when `downstream_pause` is 0 and any `fifo_empty` bit is 0. Otherwise it stays in IDLE.
- POP always goes to CAPTURE. A pop in flight is never cancelled by pause.
- CAPTURE registers `data_in[grant]` into `data_out` and `grant` into `src_id`. It then goes to POP if the IDLE condition holds, otherwise to IDLE.
- Grant selection is evaluated on entry to POP:
  - If `burst_cnt < BURST` and the current grant's FIFO is non-empty, keep the grant and increment `burst_cnt`.
  - Otherwise, pick the first non-empty FIFO searching from `last_grant+1`, wrapping modulo `NUM_FIFOS`, and set `burst_cnt = 1`.
- A burst ends early when its FIFO goes empty. The search then continues from that FIFO+1.
- `burst_cnt` width is `clog2(BURST+1)`. It saturates and never wraps.
- `pop` is combinationally gated so that it is only asserted to a FIFO sampled non-empty in the same cycle. `pop_error` is a checker and must never fire in a legal system. It clears only on reset.

## Timing
- Reset values:
  - Outputs: `pop`=0, `valid_out`=0, `data_out`=0, `src_id`=0, `pop_error`=0.
  - Internal: FSM in IDLE, `last_grant`=`NUM_FIFOS-1` (so the first grant is FIFO 0), `burst_cnt`=0.
- Latency:
  - `pop` high in cycle t.
  - FIFO data is valid in cycle t+1.
  - `valid_out` is high for exactly one cycle at t+2.
- Throughput: at most one word per 2 cycles. The next `pop` can coincide with `valid_out` of the previous word.
- Pause:
  - `downstream_pause` is sampled in IDLE and CAPTURE only.
  - A pause rising during POP still yields one `valid_out` 2 cycles later.
  - Downstream must tolerate one word after asserting pause.
- Reset mid-operation: any in-flight pop is discarded and no `valid_out` follows. The FIFO-side word is lost by design; the FIFOs are reset together.
- All FIFOs empty: remain in IDLE and keep `last_grant`.

## Structure
- Shared package `pcie_sw_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_POP`, `ST_CAPTURE`;
  - default `DATA_SIZE`/`NUM_FIFOS` constants;
  - the `src_id` width function.
- One sub-module, `rr_select`: combinational round-robin search. Inputs are the request vector and the start index; outputs are the one-hot grant, the encoded grant and an `any` flag. Everything else (FSM, burst counter, capture registers) stays in `fifo_pop_arbiter`.

## Test plan
- Reset, then FIFO 2 is the only non-empty FIFO, holding 0xA5 → `pop`=0100 at cycle 1, `valid_out`=1 with `data_out`=0xA5 and `src_id`=2 at cycle 3, then back to IDLE.
- All four FIFOs hold 3 words each, `BURST`=2 → `src_id` sequence 0,0,1,1,2,2,3,3,0,1,2,3, one `valid_out` every 2 cycles, then IDLE.
- FIFO 1 holds 1 word, FIFO 3 holds 4 words, `BURST`=2 → sequence 1,3,3,1? No: 1,3,3,3,3. After FIFO 1 empties, only FIFO 3 remains and its grant renews.
- Raise `downstream_pause` in the cycle of a POP → that word still arrives 2 cycles later, no further `pop` while paused, and popping resumes the cycle after pause drops in IDLE.
- Assert `reset` in the POP cycle → no `valid_out`, all outputs 0 next cycle, and the first grant afterwards is the lowest-index non-empty FIFO.
- Force a `fifo_empty` bit to toggle in the POP cycle (checker test) → `pop` drops for that FIFO, `pop_error` remains 0, and the sticky path is verified via a forced-error bind.
